// File: rtl/serial_pair_serializer_pkg.sv
// Shared types and helpers for the serial pair serializer.
// Optional LSB-first ordering is selected by SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01
    } state_t;

    // Bit counter width for a word of the given length (at least one bit).
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_pair_serializer_shift_reg.sv
// Parallel-load shift register emitting one serial bit per shift.
// SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN selects right shift / LSB out; default is left shift / MSB out.
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0;
        end else if (load) begin
            sh <= din;
        end else if (shift) begin
`ifdef SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN
            sh <= {1'b0, sh[WIDTH-1:1]};
`else
            sh <= {sh[WIDTH-2:0], 1'b0};
`endif
        end
    end

`ifdef SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN
    assign dout = sh[0];
`else
    assign dout = sh[WIDTH-1];
`endif

endmodule

// File: rtl/serial_pair_serializer.sv
// Serializes operand pairs in lockstep with first/last framing and bubble-free reload.
// Bit order follows SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN (default MSB first).
module serial_pair_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_word,
    input  logic [WIDTH-1:0] b_word,
    output logic             a,
    output logic             b,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   bit_cnt;
    logic            last_bit;
    logic            accept;
    logic            shift_en;
    logic            a_bit;
    logic            b_bit;

    assign last_bit = (state == ST_SHIFT) && (bit_cnt == LAST_CNT);
    // Ready depends only on state and counter, never on in_valid.
    assign in_ready = rst_n & ((state == ST_IDLE) | last_bit);
    assign accept   = in_valid & in_ready;
    assign shift_en = (state == ST_SHIFT) & ~accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_SHIFT;
            ST_SHIFT: if (last_bit && !accept) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Counter is cleared on load and on leaving the word, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (accept) begin
            bit_cnt <= '0;
        end else if ((state == ST_SHIFT) && !last_bit) begin
            bit_cnt <= bit_cnt + 1'b1;
        end else begin
            bit_cnt <= '0;
        end
    end

    serial_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (shift_en),
        .din   (a_word),
        .dout  (a_bit)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (shift_en),
        .din   (b_word),
        .dout  (b_bit)
    );

    assign out_valid = (state == ST_SHIFT);
    assign a         = out_valid & a_bit;
    assign b         = out_valid & b_bit;
    assign out_first = out_valid & (bit_cnt == '0);
    assign out_last  = last_bit;

endmodule

// File: tb/tb_serial_pair_serializer.sv
// Randomized self-checking bench for serial_pair_serializer against a word-queue reference model.
// Honors SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN for expected bit order.
module tb_serial_pair_serializer;

    localparam int W  = 4;
    localparam int W8 = 8;
`ifdef SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a_word = '0;
    logic [W-1:0]  b_word = '0;
    logic          a, b, out_valid, out_first, out_last;

    logic          in_valid8 = 1'b0;
    logic          in_ready8;
    logic [W8-1:0] a_word8 = '0;
    logic [W8-1:0] b_word8 = '0;
    logic          a8, b8, out_valid8, out_first8, out_last8;

    int n_cmp = 0;
    int n_bad = 0;

    // Each entry is one expected output cycle: {a, b, out_first, out_last}.
    logic [3:0] exp_q[$];
    wire  [3:0] obs = {a, b, out_first, out_last};

    always #5 clk = ~clk;

    serial_pair_serializer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_word(a_word), .b_word(b_word), .a(a), .b(b),
        .out_valid(out_valid), .out_first(out_first), .out_last(out_last)
    );

    serial_pair_serializer #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a_word(a_word8), .b_word(b_word8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_first(out_first8), .out_last(out_last8)
    );

    function automatic logic [3:0] exp_now();
        return (exp_q.size() != 0) ? exp_q[0] : 4'b0000;
    endfunction

    // Ready while idle or while the final bit of the current word is on the wire.
    function automatic logic exp_ready();
        return rst_n && (exp_q.size() <= 1);
    endfunction

    task automatic push_word(input logic [W-1:0] aw, input logic [W-1:0] bw);
        for (int i = 0; i < W; i++) begin
            int idx;
            idx = LSB ? i : (W - 1 - i);
            exp_q.push_back({aw[idx], bw[idx], (i == 0), (i == W - 1)});
        end
    endtask

    // Drive one cycle of input, advance the model across the edge, settle #1 after it.
    task automatic drive_cycle(input logic v, input logic [W-1:0] aw, input logic [W-1:0] bw);
        logic acc;
        in_valid = v;
        a_word   = aw;
        b_word   = bw;
        acc = v && exp_ready();
        @(posedge clk);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (acc) push_word(aw, bw);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({a, b, out_valid, out_first, out_last, in_ready} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b required 000000", {a, b, out_valid, out_first, out_last, in_ready});
        end
        n_cmp++;
        if ({a8, b8, out_valid8, in_ready8} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_outputs8: got %b required 0000", {a8, b8, out_valid8, in_ready8});
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: got %b required 1", in_ready);
        end
    endtask

    task automatic test_single_word();
        logic [W-1:0] av, bv, exp_av, exp_bv;
        exp_av = LSB ? 4'b0101 : 4'b1010;
        exp_bv = 4'b1001;
        drive_cycle(1'b1, 4'b1010, 4'b1001);
        for (int i = 0; i < W; i++) begin
            n_cmp++;
            if (obs !== exp_now() || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL single_bit%0d: got %b/%b required %b/1", i, obs, out_valid, exp_now());
            end
            av[W - 1 - i] = a;
            bv[W - 1 - i] = b;
            drive_cycle(1'b0, 4'($urandom), 4'($urandom));
        end
        n_cmp++;
        if (av !== exp_av || bv !== exp_bv) begin
            n_bad++;
            $display("FAIL single_stream: got a=%b b=%b required a=%b b=%b", av, bv, exp_av, exp_bv);
        end
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL single_after: got valid=%b ready=%b required valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] av, bv, exp_av, exp_bv;
        logic       sent2;
        logic       r;
        exp_av = LSB ? 8'b11111100 : 8'b11110011;
        exp_bv = LSB ? 8'b00000011 : 8'b00001100;
        sent2 = 1'b0;
        drive_cycle(1'b1, 4'hF, 4'h0);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (obs !== exp_now() || out_valid !== 1'b1 || in_ready !== exp_ready()) begin
                n_bad++;
                $display("FAIL b2b_bit%0d: got %b/%b/rdy%b required %b/1/rdy%b",
                         i, obs, out_valid, in_ready, exp_now(), exp_ready());
            end
            av[7 - i] = a;
            bv[7 - i] = b;
            if (!sent2) begin
                r = exp_ready();
                drive_cycle(1'b1, 4'h3, 4'hC);
                if (r) sent2 = 1'b1;
            end else begin
                drive_cycle(1'b0, 4'h0, 4'h0);
            end
        end
        n_cmp++;
        if (av !== exp_av || bv !== exp_bv) begin
            n_bad++;
            $display("FAIL b2b_stream: got a=%b b=%b required a=%b b=%b", av, bv, exp_av, exp_bv);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_end: got valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_idle_ignored();
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b0, 4'($urandom), 4'($urandom));
            n_cmp++;
            if ({out_valid, a, b, out_first, out_last} !== 5'b0) begin
                n_bad++;
                $display("FAIL idle%0d: got %b required 00000", i, {out_valid, a, b, out_first, out_last});
            end
        end
        drive_cycle(1'b1, 4'($urandom), 4'($urandom));
        for (int i = 0; i < W; i++) begin
            n_cmp++;
            if (obs !== exp_now() || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL midword_change%0d: got %b required %b", i, obs, exp_now());
            end
            drive_cycle(1'b0, 4'($urandom), 4'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] av, exp_av;
        exp_av = LSB ? 4'b1000 : 4'b0001;
        drive_cycle(1'b1, 4'b1111, 4'b1111);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (obs !== exp_now()) begin
                n_bad++;
                $display("FAIL pre_reset%0d: got %b required %b", i, obs, exp_now());
            end
            drive_cycle(1'b0, 4'h0, 4'h0);
        end
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_cmp++;
        if ({a, b, out_valid, out_first, out_last, in_ready} !== 6'b0) begin
            n_bad++;
            $display("FAIL async_reset: got %b required 000000", {a, b, out_valid, out_first, out_last, in_ready});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL after_reset: got ready=%b valid=%b required ready=1 valid=0", in_ready, out_valid);
        end
        drive_cycle(1'b1, 4'b0001, 4'b0110);
        for (int i = 0; i < W; i++) begin
            n_cmp++;
            if (obs !== exp_now() || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL post_reset_bit%0d: got %b required %b", i, obs, exp_now());
            end
            av[W - 1 - i] = a;
            drive_cycle(1'b0, 4'h0, 4'h0);
        end
        n_cmp++;
        if (av !== exp_av) begin
            n_bad++;
            $display("FAIL post_reset_stream: got %b required %b", av, exp_av);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            n_cmp++;
            if (obs !== exp_now() || out_valid !== (exp_q.size() != 0) || in_ready !== exp_ready()) begin
                n_bad++;
                $display("FAIL random%0d: got %b v%b r%b required %b v%b r%b", i, obs, out_valid,
                         in_ready, exp_now(), (exp_q.size() != 0), exp_ready());
            end
            n_cmp++;
            if (out_first && out_last) begin
                n_bad++;
                $display("FAIL first_last_together%0d: got 11 required not both", i);
            end
            drive_cycle($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom));
        end
        repeat (W + 1) drive_cycle(1'b0, 4'h0, 4'h0);
    endtask

    // Sends one 8-bit pair and rebuilds both words from the stream, as a serial comparator would see them.
    task automatic run8(input logic [W8-1:0] aw, input logic [W8-1:0] bw,
                        output logic [W8-1:0] ra, output logic [W8-1:0] rb, output logic done);
        logic [W8-1:0] acc_a, acc_b;
        acc_a = '0;
        acc_b = '0;
        done  = 1'b0;
        in_valid8 = 1'b1;
        a_word8   = aw;
        b_word8   = bw;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        a_word8   = ~aw;
        for (int i = 0; i < 12 && !done; i++) begin
            if (out_valid8) begin
                if (out_first8) begin
                    acc_a = '0;
                    acc_b = '0;
                end
                acc_a = LSB ? {a8, acc_a[W8-1:1]} : {acc_a[W8-2:0], a8};
                acc_b = LSB ? {b8, acc_b[W8-1:1]} : {acc_b[W8-2:0], b8};
                if (out_last8) done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        ra = acc_a;
        rb = acc_b;
    endtask

    task automatic test_comparator_chain();
        logic [W8-1:0] ra, rb;
        logic          done;
        run8(8'h5A, 8'h5B, ra, rb, done);
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL chain_lt_timeout: got no out_last required out_last within 12 cycles");
        end
        n_cmp++;
        if ((ra < rb) !== 1'b1 || ra !== 8'h5A) begin
            n_bad++;
            $display("FAIL chain_a_less_b: got a=%h b=%h required a=5a b=5b a_less_b=1", ra, rb);
        end
        run8(8'h5B, 8'h5B, ra, rb, done);
        n_cmp++;
        if (!done || (ra == rb) !== 1'b1 || ra !== 8'h5B) begin
            n_bad++;
            $display("FAIL chain_a_eq_b: got done=%b a=%h b=%h required done=1 a=b=5b", done, ra, rb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_idle_ignored();
        test_reset_mid();
        test_random();
        test_comparator_chain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_pair_serializer.md
Name: serial_pair_serializer

Overview:
- Parallel-to-serial transmitter for the serial comparators.
- Accepts a pair of WIDTH-bit operands (a_word, b_word) through a valid/ready handshake.
- Shifts both operands out in lockstep, one bit per clock, most significant bit first. This output feeds the serial comparator inputs a/b directly.
- Supplies framing (out_valid, out_first, out_last) so downstream logic can delimit words. Back-to-back words stream with no bubble.

Parameters:
- WIDTH, 8, operand width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- in_valid  input  1  a_word/b_word hold a pair to send.
- in_ready  output  1  serializer can accept a pair this cycle.
- a_word  input  WIDTH  operand A.
- b_word  input  WIDTH  operand B.
- a  output  1  current serial bit of A.
- b  output  1  current serial bit of B.
- out_valid  output  1  a/b carry a valid bit this cycle.
- out_first  output  1  current bit is the first bit of a word (MSB by default).
- out_last  output  1  current bit is the last bit of a word.

Behaviour:
- Reset values: state = ST_IDLE; shift registers = 0; bit_cnt = 0.
  - While rst_n is low: a = b = out_valid = out_first = out_last = 0 and in_ready = 0.
  - in_ready rises in the first cycle after rst_n deasserts.
- FSM states (2-bit enum): ST_IDLE and ST_SHIFT.
- in_ready = rst_n & (state == ST_IDLE | (state == ST_SHIFT & bit_cnt == WIDTH-1)).
  - in_ready is combinational from state and counter only; it never depends on in_valid.
- accept = in_valid & in_ready. On accept:
  - load sh_a <= a_word and sh_b <= b_word;
  - bit_cnt <= 0;
  - state <= ST_SHIFT.
- Operands are sampled only on accept; changes to a_word/b_word at any other time are ignored.
- Latency: accept at edge N puts the first bit on a/b in cycle N+1. A word occupies exactly WIDTH consecutive cycles.
- In ST_SHIFT:
  - a = sh_a[WIDTH-1], b = sh_b[WIDTH-1], out_valid = 1;
  - out_first = (bit_cnt == 0), out_last = (bit_cnt == WIDTH-1);
  - each clock shifts both registers left by one (zero fill) and increments bit_cnt.
- Last bit (bit_cnt == WIDTH-1):
  - with accept: reload the new pair, stay in ST_SHIFT, no gap cycle;
  - without accept: go to ST_IDLE.
- In ST_IDLE: a = b = out_valid = out_first = out_last = 0.
- Invariants:
  - out_first and out_last are never asserted together (WIDTH >= 2).
  - Framing outputs are 0 whenever out_valid = 0.
- Reset mid-word: the word is aborted immediately and no partial completion occurs. After reset, the next accepted pair starts with out_first = 1.
- bit_cnt width is $clog2(WIDTH). bit_cnt never exceeds WIDTH-1; the reload/idle decision is taken at WIDTH-1, so the counter never wraps.
- Unknown state encoding returns to ST_IDLE via the default branch.

Optional Feature:
- Macro: SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN.
- Defined:
  - bits leave least significant first: a = sh_a[0], b = sh_b[0];
  - registers shift right with zero fill;
  - out_first marks the LSB and out_last marks the MSB;
  - handshake and timing are unchanged. This ordering is for driving the LSB-first comparator.
- Undefined: MSB-first ordering as specified above.

Decomposition:
- Package serial_pkg holds:
  - the state enum type (ST_IDLE, ST_SHIFT);
  - a localparam-style function for counter width.
- One sub-module is natural: serial_shift_reg.
  - WIDTH-bit parallel-load shift register with load and shift enables and async active-low reset.
  - Instantiated twice, once for A and once for B; direction is selected by the macro.
- Top module holds the FSM, bit counter and handshake.

Test Plan:
- Single word (WIDTH=4): a_word=4'b1010, b_word=4'b1001 accepted at edge N.
  - Cycles N+1..N+4: a = 1,0,1,0 and b = 1,0,0,1.
  - out_first only at N+1; out_last only at N+4.
  - out_valid = 0 and in_ready = 1 at N+5.
- Back-to-back: in_valid held high with pairs (4'hF,4'h0) then (4'h3,4'hC).
  - in_ready pulses on each last-bit cycle.
  - Eight contiguous valid cycles: a = 1,1,1,1,0,0,1,1 and b = 0,0,0,0,1,1,0,0.
- Idle / ignored data: in_valid = 0 while a_word toggles for 10 cycles.
  - out_valid stays 0 and a = b = 0 throughout.
  - Changing a_word mid-word does not affect shifted bits.
- Reset mid-word: assert rst_n low at bit 2 of 4'b1111.
  - All outputs go 0 in the same cycle, asynchronously.
  - After release, in_ready = 1; the next pair 4'b0001 emits 0,0,0,1 with correct framing.
- Chained with the MSB-first serial comparator, WIDTH=8, a=8'h5A, b=8'h5B, comparator reset on out_first.
  - On the out_last cycle the comparator reports a_less_b = 1.
  - With a = b = 8'h5B it reports a_eq_b = 1.
- Macro defined, WIDTH=4: a_word = 4'b0001 emits a = 1,0,0,0 with out_first on the first (LSB) bit.
